pdm_capture: RTL

PDM_CAPTURE -- requirements
Module: pdm_capture

---
 rtl/pdm_capture.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pdm_capture.sv
// PDM microphone capture: divides clk down to m_clk, counts ones over 128-bit windows and streams
// saturated amplitudes to a sample RAM. Define PDM_RISING_SAMPLE_EN to sample on the m_clk rising transition.
module pdm_capture #(
    parameter  int CLK_FREQ     = 100,
    parameter  int RAM_SIZE     = 16384,
    parameter  int MCLK_FREQ    = 2500000,
    localparam int SAMPLE_COUNT = 128,
    localparam int SAMPLE_BITS  = $clog2(SAMPLE_COUNT),
    localparam int ADDR_W       = $clog2(RAM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_capture,
    output logic                   m_clk,
    input  logic                   m_data,
    output logic [ADDR_W-1:0]      ram_wraddr,
    output logic [SAMPLE_BITS-1:0] ram_wrdata,
    output logic                   ram_we,
    output logic                   capturing,
    output logic                   capture_done,
    output logic [15:0]            set_led
);

    localparam int MCLK_HALF = (CLK_FREQ * 1000000) / (2 * MCLK_FREQ);
    localparam int DIV_W     = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

`ifdef PDM_RISING_SAMPLE_EN
    localparam logic EVT_LEVEL = 1'b0;
`else
    localparam logic EVT_LEVEL = 1'b1;
`endif

    // A full window holds 128 bits, so the count can reach 128 and must clip to 127.
    function automatic logic [SAMPLE_BITS-1:0] sat_ones(input logic [7:0] n);
        return (n > 8'(SAMPLE_COUNT - 1)) ? SAMPLE_BITS'(SAMPLE_COUNT - 1) : n[SAMPLE_BITS-1:0];
    endfunction

    logic [2:0]             start_sync_q, start_sync_d;
    logic [1:0]             mdat_sync_q, mdat_sync_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   m_clk_q, m_clk_d;
    logic                   capturing_q, capturing_d;
    logic [SAMPLE_BITS-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]             ones_q, ones_d;
    logic [ADDR_W-1:0]      ram_wraddr_q, ram_wraddr_d;
    logic [SAMPLE_BITS-1:0] ram_wrdata_q, ram_wrdata_d;
    logic                   ram_we_q, ram_we_d;
    logic                   capture_done_q, capture_done_d;
    logic [15:0]            set_led_q, set_led_d;

    logic       div_wrap;
    logic       sample_evt;
    logic       start_edge;
    logic       sample_bit;
    logic [7:0] ones_next;
    logic [3:0] led_idx;

    always_comb begin
        start_sync_d   = {start_sync_q[1:0], start_capture};
        mdat_sync_d    = {mdat_sync_q[0], m_data};
        div_d          = div_q;
        m_clk_d        = m_clk_q;
        capturing_d    = capturing_q;
        bit_cnt_d      = bit_cnt_q;
        ones_d         = ones_q;
        ram_wraddr_d   = ram_wraddr_q;
        ram_wrdata_d   = ram_wrdata_q;
        ram_we_d       = 1'b0;
        capture_done_d = 1'b0;
        set_led_d      = 16'h0000;

        div_wrap   = (div_q == DIV_W'(MCLK_HALF - 1));
        sample_evt = div_wrap && (m_clk_q == EVT_LEVEL);
        // Third synchronizer flop doubles as the edge-detect history.
        start_edge = start_sync_q[1] && !start_sync_q[2];
        sample_bit = mdat_sync_q[1];
        ones_next  = ones_q + {7'b0, sample_bit};
        led_idx    = ~ram_wraddr_q[ADDR_W-1 -: 4];

        if (div_wrap) begin
            div_d   = '0;
            m_clk_d = ~m_clk_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (start_edge) begin
            capturing_d  = 1'b1;
            ram_wraddr_d = '0;
            bit_cnt_d    = '0;
            ones_d       = '0;
        end else if (capturing_q) begin
            if (sample_evt) begin
                bit_cnt_d = bit_cnt_q + SAMPLE_BITS'(1);
                if (bit_cnt_q == SAMPLE_BITS'(SAMPLE_COUNT - 1)) begin
                    ones_d       = '0;
                    ram_we_d     = 1'b1;
                    ram_wrdata_d = sat_ones(ones_next);
                    set_led_d    = 16'(1) << led_idx;
                end else begin
                    ones_d = ones_next;
                end
            end
            // Address advances once the write has been presented for its single cycle.
            if (ram_we_q) begin
                if (ram_wraddr_q == ADDR_W'(RAM_SIZE - 1)) begin
                    ram_wraddr_d   = '0;
                    capturing_d    = 1'b0;
                    capture_done_d = 1'b1;
                end else begin
                    ram_wraddr_d = ram_wraddr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync_q   <= '0;
            mdat_sync_q    <= '0;
            div_q          <= '0;
            m_clk_q        <= 1'b0;
            capturing_q    <= 1'b0;
            bit_cnt_q      <= '0;
            ones_q         <= '0;
            ram_wraddr_q   <= '0;
            ram_wrdata_q   <= '0;
            ram_we_q       <= 1'b0;
            capture_done_q <= 1'b0;
            set_led_q      <= '0;
        end else begin
            start_sync_q   <= start_sync_d;
            mdat_sync_q    <= mdat_sync_d;
            div_q          <= div_d;
            m_clk_q        <= m_clk_d;
            capturing_q    <= capturing_d;
            bit_cnt_q      <= bit_cnt_d;
            ones_q         <= ones_d;
            ram_wraddr_q   <= ram_wraddr_d;
            ram_wrdata_q   <= ram_wrdata_d;
            ram_we_q       <= ram_we_d;
            capture_done_q <= capture_done_d;
            set_led_q      <= set_led_d;
        end
    end

    assign m_clk        = m_clk_q;
    assign ram_wraddr   = ram_wraddr_q;
    assign ram_wrdata   = ram_wrdata_q;
    assign ram_we       = ram_we_q;
    assign capturing    = capturing_q;
    assign capture_done = capture_done_q;
    assign set_led      = set_led_q;

endmodule
